// File: rtl/regbank16_write.sv
// regbank16_write
//   Write side of a 16-entry register bank. A 4-bit write address is decoded
//   into one-hot enables gated by a valid/ready handshake. A 16-cycle
//   sequential clear sweep zeroes the bank without holding reset. All
//   register contents are presented flattened for the read-side select trees.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   wr_valid   in   write request present
//   wr_ready   out  bank can accept a write this cycle (combinational)
//   wr_addr    in   destination register index
//   wr_data    in   data to write
//   clear_req  in   single-cycle request to start a clear sweep
//   busy       out  clear sweep in progress
//   wr_onehot  out  registered one-hot of the write performed at the last edge
//   regs_out   out  register i on bits [i*WIDTH +: WIDTH]
module regbank16_write #(
  parameter int WIDTH    = 64,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [15:0]           wr_onehot,
  output logic [16*WIDTH-1:0]   regs_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic [15:0] onehot_q, onehot_d;

  logic        wr_accept;
  logic [15:0] wr_dec;
  logic [15:0] clr_sel;

  assign wr_ready  = (state_q == ST_IDLE) && !reset;
  assign wr_accept = wr_valid && wr_ready;

  // Write decode; with a zero register, entry 15 never gets a write enable,
  // so an accepted write to it is consumed but leaves no one-hot trace.
  always_comb begin
    wr_dec = 16'h0000;
    if (wr_accept) begin
      wr_dec = 16'h0001 << wr_addr;
    end
    if (ZERO_REG) begin
      wr_dec[15] = 1'b0;
    end
  end

  // Sweep select: one entry per cycle while clearing.
  always_comb begin
    clr_sel = 16'h0000;
    if (state_q == ST_CLEAR) begin
      clr_sel = 16'h0001 << idx_q;
    end
  end

  // NOTE: every variable written here gets a default first, otherwise a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    onehot_d = wr_dec;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        // clear_req is ignored here: no restart, no queueing.
        idx_d = idx_q + 4'd1;  // wraps 15 -> 0 on the exit edge
        if (idx_q == 4'd15) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      busy_q   <= 1'b0;
      onehot_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      onehot_q <= onehot_d;
    end
  end

  assign busy      = busy_q;
  assign wr_onehot = onehot_q;

  // Register array: each entry has its own enable (write decode OR sweep
  // select). Sweep and write never coincide because wr_ready is low in CLEAR.
  for (genvar i = 0; i < 16; i++) begin : g_reg
    if (ZERO_REG && i == 15) begin : g_zero
      assign regs_out[i*WIDTH +: WIDTH] = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] reg_q, reg_d;
      logic             reg_en;

      assign reg_en = wr_dec[i] | clr_sel[i];

      always_comb begin
        reg_d = reg_q;
        if (reg_en) begin
          reg_d = clr_sel[i] ? '0 : wr_data;
        end
      end

      // NOTE: the bank is reset explicitly, not left to power-up contents,
      // because reset must return every entry to zero immediately.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_out[i*WIDTH +: WIDTH] = reg_q;
    end
  end

endmodule

// File: tb/tb_regbank16_write.sv
module tb_regbank16_write;

  localparam int W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic [3:0]      wr_addr;
  logic [W-1:0]    wr_data;
  logic            clear_req;

  logic            wr_ready, busy;
  logic [15:0]     wr_onehot;
  logic [16*W-1:0] regs_out;

  logic            wr_ready0, busy0;
  logic [15:0]     wr_onehot0;
  logic [16*W-1:0] regs_out0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regbank16_write #(.WIDTH(W), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
    .busy(busy), .wr_onehot(wr_onehot), .regs_out(regs_out)
  );

  regbank16_write #(.WIDTH(W), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
    .busy(busy0), .wr_onehot(wr_onehot0), .regs_out(regs_out0)
  );

  function automatic logic [W-1:0] reg_of(input logic [16*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after the edge and
  // inputs change at the same point, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] val);
    wr_valid = 1'b1;
    wr_data  = val;
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_addr = 4'd0; wr_data = '0; clear_req = 1'b0;
    #2;
    checks++;
    if (regs_out !== '0 || regs_out0 !== '0) begin
      failures++; $display("FAIL reset_regs got=%h/%h want=0", regs_out, regs_out0);
    end
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0 || wr_onehot !== 16'h0) begin
      failures++; $display("FAIL reset_ctrl busy=%b ready=%b onehot=%h want 0/0/0000",
                           busy, wr_ready, wr_onehot);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", wr_ready);
    end
  endtask

  task automatic test_basic_write();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 64'hDEAD_BEEF_0000_0003;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (reg_of(regs_out, 3) !== 64'hDEAD_BEEF_0000_0003) begin
      failures++; $display("FAIL basic_reg3 got=%h want=deadbeef00000003", reg_of(regs_out, 3));
    end
    checks++;
    if (wr_onehot !== 16'h0008) begin
      failures++; $display("FAIL basic_onehot got=%h want=0008", wr_onehot);
    end
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        checks++;
        if (reg_of(regs_out, i) !== '0) begin
          failures++; $display("FAIL basic_other%0d got=%h want=0", i, reg_of(regs_out, i));
        end
      end
    end
    tick();
    checks++;
    if (wr_onehot !== 16'h0000) begin
      failures++; $display("FAIL basic_onehot_drop got=%h want=0000", wr_onehot);
    end
  endtask

  task automatic test_decode();
    logic [15:0] exp1, exp0;
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i);
      wr_data = 64'(i + 1);
      tick();
      exp0 = 16'h0001 << i;
      exp1 = (i == 15) ? 16'h0000 : exp0;
      checks++;
      if (wr_onehot !== exp1 || wr_onehot0 !== exp0) begin
        failures++; $display("FAIL decode_onehot addr=%0d got=%h/%h want=%h/%h",
                             i, wr_onehot, wr_onehot0, exp1, exp0);
      end
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (reg_of(regs_out, i) !== ((i == 15) ? 64'd0 : 64'(i + 1)) ||
          reg_of(regs_out0, i) !== 64'(i + 1)) begin
        failures++; $display("FAIL decode_reg%0d got=%h/%h", i, reg_of(regs_out, i),
                             reg_of(regs_out0, i));
      end
    end
  endtask

  task automatic test_clear_sweep();
    logic [W-1:0] e1, e0;
    int bad, busy_cycles;
    fill(ONES);
    clear_req = 1'b1;
    tick();  // start edge
    clear_req = 1'b0;
    busy_cycles = 0;
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || reg_of(regs_out, 0) !== ONES) begin
      failures++; $display("FAIL sweep_start busy=%b ready=%b reg0=%h want 1/0/ones",
                           busy, wr_ready, reg_of(regs_out, 0));
    end
    if (busy) busy_cycles++;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) clear_req = 1'b1;  // must be ignored mid-sweep
      tick();
      clear_req = 1'b0;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        e0 = (k < c) ? 64'd0 : ONES;
        e1 = (k == 15) ? 64'd0 : e0;
        if (reg_of(regs_out, k) !== e1 || reg_of(regs_out0, k) !== e0) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL sweep_regs cycle=%0d wrong_entries=%0d want=0", c, bad);
      end
      checks++;
      if (busy !== (c < 16) || wr_ready !== (c >= 16)) begin
        failures++; $display("FAIL sweep_busy cycle=%0d busy=%b ready=%b want=%b/%b",
                             c, busy, wr_ready, c < 16, c >= 16);
      end
      if (busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 16) begin
      failures++; $display("FAIL sweep_busy_len got=%0d want=16", busy_cycles);
    end
  endtask

  task automatic test_stall();
    int pulses;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 64'h55;
    pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (wr_onehot !== 16'h0) pulses++;
      checks++;
      if (reg_of(regs_out, 5) !== 64'd0) begin
        failures++; $display("FAIL stall_reg5 cycle=%0d got=%h want=0", c, reg_of(regs_out, 5));
      end
    end
    tick();  // first edge after busy falls: write accepted
    wr_valid = 1'b0;
    checks++;
    if (reg_of(regs_out, 5) !== 64'h55 || wr_onehot !== 16'h0020) begin
      failures++; $display("FAIL stall_accept reg5=%h onehot=%h want=55/0020",
                           reg_of(regs_out, 5), wr_onehot);
    end
    if (wr_onehot !== 16'h0) pulses++;
    tick();
    if (wr_onehot !== 16'h0) pulses++;
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL stall_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 64'h22; clear_req = 1'b1;
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || wr_onehot !== 16'h0004) begin
      failures++; $display("FAIL simul_start busy=%b onehot=%h want=1/0004", busy, wr_onehot);
    end
    for (int c = 0; c < 4; c++) begin
      exp = (c < 3) ? 64'h22 : 64'h0;
      checks++;
      if (reg_of(regs_out, 2) !== exp) begin
        failures++; $display("FAIL simul_reg2 cycle=%0d got=%h want=%h", c, reg_of(regs_out, 2), exp);
      end
      tick();
    end
    for (int n = 0; n < 20 && busy; n++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL simul_timeout busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill(64'hAA);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 7; c++) tick();  // index now 7
    checks++;
    if (reg_of(regs_out, 6) !== 64'h0 || reg_of(regs_out, 7) !== 64'hAA || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre reg6=%h reg7=%h busy=%b want=0/aa/1",
                           reg_of(regs_out, 6), reg_of(regs_out, 7), busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0 || wr_onehot !== 16'h0 ||
        regs_out !== '0 || regs_out0 !== '0) begin
      failures++; $display("FAIL mid_reset busy=%b ready=%b onehot=%h regs_nonzero=%b",
                           busy, wr_ready, wr_onehot, (regs_out | regs_out0) != '0);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_release ready=%b busy=%b want=1/0", wr_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_decode();
    test_clear_sweep();
    test_stall();
    test_simultaneous();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
